// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the combinational instruction
// memory, buffers fetched {pc, instr} pairs in a small prefetch FIFO and
// presents the head to decode through a valid/ready handshake.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [31:0]      imem_address_o,
  input  logic [31:0]      imem_instruction_i,
  input  logic             fetch_enable_i,
  output logic             instr_valid_o,
  output logic [31:0]      instruction_o,
  output logic [31:0]      instr_pc_o,
  output logic [31:0]      instr_pc_plus4_o,
  input  logic             instr_ready_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  output logic [CNT_W-1:0] fifo_count_o
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_RESET  = RESET_PC & WORD_MASK;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t             mem_q [DEPTH];

  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  entry_t             head_q, head_d;
  logic [31:0]        plus4_q, plus4_d;

  logic               pop_c;
  logic               push_c;
  logic               full_c;
  logic               bypass_c;
  entry_t             fetch_entry_c;

  // Handshake qualifiers for this cycle
  always_comb begin
    full_c        = (count_q == CNT_W'(DEPTH));
    pop_c         = valid_q & instr_ready_i;
    push_c        = fetch_enable_i & ~branch_taken_i & (~full_c | pop_c);
    fetch_entry_c = '{pc: fetch_pc_q, instr: imem_instruction_i};
    // Fetched word becomes the new head when nothing older survives this cycle
    bypass_c      = (count_q - CNT_W'(pop_c)) == '0;
  end

  // Next-state for PC, pointers, occupancy and the registered head view
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    valid_d    = valid_q;
    head_d     = head_q;
    plus4_d    = plus4_q;

    if (branch_taken_i) begin
      // Redirect flushes everything; head view keeps its last (stale) value
      fetch_pc_d = branch_target_i & WORD_MASK;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      valid_d    = 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      valid_d = (count_d != '0);
      if (count_d != '0) begin
        head_d  = bypass_c ? fetch_entry_c : mem_q[rd_ptr_d];
        plus4_d = head_d.pc + 32'd4;
      end
    end
  end

  // Control and head registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= PC_RESET;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      plus4_q    <= 32'd4;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      plus4_q    <= plus4_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= fetch_entry_c;
    end
  end

  assign imem_address_o   = fetch_pc_q;
  assign instr_valid_o    = valid_q;
  assign instruction_o    = head_q.instr;
  assign instr_pc_o       = head_q.pc;
  assign instr_pc_plus4_o = plus4_q;
  assign fifo_count_o     = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_instruction_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic             clk;
  logic             rst_n;
  logic             fe, rdy, br;
  logic [31:0]      tgt;

  logic [31:0]      imem_addr, imem_instr;
  logic             instr_valid;
  logic [31:0]      instruction, instr_pc, instr_pc4;
  logic [CNT_W-1:0] fifo_count;

  logic [31:0]      w_imem_addr, w_imem_instr;
  logic             w_valid;
  logic [31:0]      w_instruction, w_pc, w_pc4;
  logic [CNT_W-1:0] w_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  entry_t      q[$];
  logic [31:0] m_pc;
  logic [31:0] disp_pc, disp_instr;
  logic [31:0] acc[$];

  // Memory contents: mem[i] = i*3
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'(a[31:2]) * 32'd3;
  endfunction

  assign imem_instr   = memf(imem_addr);
  assign w_imem_instr = memf(w_imem_addr);

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .imem_address_o     (imem_addr),
    .imem_instruction_i (imem_instr),
    .fetch_enable_i     (fe),
    .instr_valid_o      (instr_valid),
    .instruction_o      (instruction),
    .instr_pc_o         (instr_pc),
    .instr_pc_plus4_o   (instr_pc4),
    .instr_ready_i      (rdy),
    .branch_taken_i     (br),
    .branch_target_i    (tgt),
    .fifo_count_o       (fifo_count)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .imem_address_o     (w_imem_addr),
    .imem_instruction_i (w_imem_instr),
    .fetch_enable_i     (fe),
    .instr_valid_o      (w_valid),
    .instruction_o      (w_instruction),
    .instr_pc_o         (w_pc),
    .instr_pc_plus4_o   (w_pc4),
    .instr_ready_i      (rdy),
    .branch_taken_i     (br),
    .branch_target_i    (tgt),
    .fifo_count_o       (w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    acc.delete();
    m_pc       = 32'h0;
    disp_pc    = 32'h0;
    disp_instr = 32'h0;
  endtask

  // Assert reset mid-cycle, hold across an edge, release mid-cycle
  task automatic do_reset();
    fe = 1'b0; rdy = 1'b0; br = 1'b0; tgt = 32'h0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Advance one clock: apply the fetch rules to the model, then sample after the edge
  task automatic tick();
    entry_t e;
    bit     pop;
    bit     push;
    pop = (q.size() != 0) && rdy;
    if (instr_valid && rdy) acc.push_back(instr_pc);
    if (br) begin
      q.delete();
      m_pc = tgt & 32'hFFFF_FFFC;
    end else begin
      push = fe && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc    = m_pc;
        e.instr = memf(m_pc);
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    if (q.size() != 0) begin
      disp_pc    = q[0].pc;
      disp_instr = q[0].instr;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fe = 1'b0; rdy = 1'b0; br = 1'b0; tgt = 32'h0;
    model_reset();
    @(posedge clk); #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instruction); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", instr_pc); end
    checks++; if (instr_pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h expected 4", instr_pc4); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    checks++; if (w_imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_addr_w: got %h expected fffffff8", w_imem_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    do_reset();
    fe = 1'b1; rdy = 1'b1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_prevalid: got %b expected 0", instr_valid); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4) || instruction !== 32'(i * 3) ||
          instr_pc4 !== 32'(i * 4 + 4) || fifo_count !== CNT_W'(1)) begin
        errors++;
        $display("FAIL seq_head[%0d]: got v=%b pc=%h instr=%h pc4=%h cnt=%0d expected v=1 pc=%h instr=%h cnt=1",
                 i, instr_valid, instr_pc, instruction, instr_pc4, fifo_count, 32'(i * 4), 32'(i * 3));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    fe = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (fifo_count !== CNT_W'((i + 1 < 4) ? i + 1 : 4)) begin
        errors++;
        $display("FAIL stall_count[%0d]: got %0d expected %0d", i, fifo_count, (i + 1 < 4) ? i + 1 : 4);
      end
    end
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL stall_addr: got %h expected 10", imem_addr); end
    rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(k * 4) || instruction !== 32'(k * 3)) begin
        errors++;
        $display("FAIL stall_release[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 k, instr_valid, instr_pc, instruction, 32'(k * 4), 32'(k * 3));
      end
      tick();
      if (k == 0) begin
        checks++;
        if (fifo_count !== CNT_W'(4)) begin errors++; $display("FAIL stall_swap_count: got %0d expected 4", fifo_count); end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    fe = 1'b1; rdy = 1'b0;
    repeat (3) tick();
    checks++; if (fifo_count !== CNT_W'(3)) begin errors++; $display("FAIL redir_pre_count: got %0d expected 3", fifo_count); end
    br = 1'b1; tgt = 32'h43;
    tick();
    br = 1'b0; rdy = 1'b1;
    checks++;
    if (fifo_count !== '0 || instr_valid !== 1'b0 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL redir_flush: got cnt=%0d v=%b addr=%h expected cnt=0 v=0 addr=40", fifo_count, instr_valid, imem_addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instruction !== 32'd48) begin
      errors++;
      $display("FAIL redir_target: got v=%b pc=%h instr=%0d expected v=1 pc=40 instr=48", instr_valid, instr_pc, instruction);
    end
  endtask

  task automatic test_redirect_pop_full();
    do_reset();
    fe = 1'b1; rdy = 1'b0;
    repeat (4) tick();
    checks++; if (fifo_count !== CNT_W'(4)) begin errors++; $display("FAIL rpf_full: got %0d expected 4", fifo_count); end
    rdy = 1'b1; br = 1'b1; tgt = 32'h200;
    tick();
    br = 1'b0;
    checks++;
    if (fifo_count !== '0 || instr_valid !== 1'b0 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL rpf_flush: got cnt=%0d v=%b addr=%h expected cnt=0 v=0 addr=200", fifo_count, instr_valid, imem_addr);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h200 + 32'(k * 4)) begin
        errors++;
        $display("FAIL rpf_stream[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, instr_valid, instr_pc, 32'h200 + 32'(k * 4));
      end
    end
    checks++;
    if (acc.size() < 2 || acc[0] !== 32'h0 || acc[1] !== 32'h200) begin
      errors++;
      $display("FAIL rpf_accepted: got n=%0d first=%h second=%h expected first=0 second=200",
               acc.size(), (acc.size() > 0) ? acc[0] : 32'hx, (acc.size() > 1) ? acc[1] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_p4 [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    exp_p4[0] = 32'hFFFF_FFFC; exp_p4[1] = 32'h0000_0000; exp_p4[2] = 32'h0000_0004;
    do_reset();
    fe = 1'b1; rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (w_valid !== 1'b1 || w_pc !== exp_pc[k] || w_pc4 !== exp_p4[k] || w_instruction !== memf(exp_pc[k])) begin
        errors++;
        $display("FAIL wrap[%0d]: got v=%b pc=%h pc4=%h instr=%h expected pc=%h pc4=%h instr=%h",
                 k, w_valid, w_pc, w_pc4, w_instruction, exp_pc[k], exp_p4[k], memf(exp_pc[k]));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fe = 1'b1; rdy = 1'b0;
    repeat (2) tick();
    checks++; if (fifo_count !== CNT_W'(2)) begin errors++; $display("FAIL areset_pre: got %0d expected 2", fifo_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || fifo_count !== '0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL areset_immediate: got v=%b cnt=%0d addr=%h expected v=0 cnt=0 addr=0", instr_valid, fifo_count, imem_addr);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || fifo_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL areset_restart: got v=%b pc=%h cnt=%0d expected v=1 pc=0 cnt=1", instr_valid, instr_pc, fifo_count);
    end
  endtask

  task automatic test_random();
    logic            exp_v;
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      fe  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      br  = ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
      tick();
      exp_v   = (q.size() != 0);
      exp_cnt = CNT_W'(q.size());
      checks++;
      if (instr_valid !== exp_v || fifo_count !== exp_cnt || imem_addr !== m_pc ||
          instr_pc !== disp_pc || instruction !== disp_instr || instr_pc4 !== disp_pc + 32'd4) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b cnt=%0d addr=%h pc=%h instr=%h pc4=%h expected v=%b cnt=%0d addr=%h pc=%h instr=%h pc4=%h",
                 i, instr_valid, fifo_count, imem_addr, instr_pc, instruction, instr_pc4,
                 exp_v, exp_cnt, m_pc, disp_pc, disp_instr, disp_pc + 32'd4);
      end
    end
    br = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_pop_full();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Initiator side of the instruction-memory read interface. The block owns the program counter and drives the word address into the combinational instruction memory. It captures the returned word together with its PC into a small prefetch FIFO and presents it to decode with a valid/ready handshake. It sits between the instruction memory and the IF/ID boundary, and handles stalls from decode and redirects from branch resolution.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] are ignored (treated as 0).
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- ImemAddress  out  32  byte address to instruction memory; always equals FetchPC, bits [1:0] = 0.
- ImemInstruction  in  32  word returned combinationally for ImemAddress within the same cycle.
- FetchEnable  in  1  1 = fetch allowed; 0 = hold FetchPC, no push.
- InstrValid  out  1  FIFO head is valid.
- Instruction  out  32  FIFO head instruction word.
- InstrPC  out  32  PC of the FIFO head.
- InstrPCPlus4  out  32  InstrPC + 4, modulo 2^32.
- InstrReady  in  1  decode accepts the head this cycle.
- BranchTaken  in  1  redirect request.
- BranchTarget  in  32  redirect PC; bits [1:0] forced to 0.
- FifoCount  out  log2(DEPTH)+1  current occupancy.

## Operation
- State: FetchPC (32b), FIFO of DEPTH entries {pc, instr}, read pointer, write pointer, count.
- Reset (Reset_n=0, asynchronous): FetchPC=RESET_PC & ~3; FIFO pointers=0; count=0. Outputs: InstrValid=0, Instruction=0, InstrPC=0, InstrPCPlus4=4, FifoCount=0, ImemAddress=RESET_PC & ~3.
- pop = InstrValid & InstrReady.
- push = FetchEnable & ~BranchTaken & (count<DEPTH | pop).
- On push: write {FetchPC, ImemInstruction} at the write pointer, then FetchPC += 4. The add wraps 32'hFFFF_FFFC -> 0.
- On pop: advance the read pointer. Push and pop in the same cycle leave count unchanged.
- Redirect (BranchTaken=1 at an edge):
  - Has priority over everything else.
  - FIFO flushed: pointers=0, count=0.
  - FetchPC = BranchTarget & ~3.
  - No push that cycle.
  - A head popped in the same cycle counts as accepted by decode. All other entries are discarded.
- FetchEnable=0: FetchPC holds, no push. Pops continue normally.
- Full (count==DEPTH) with no pop: no push, FetchPC holds, ImemAddress stable.
- Empty: InstrValid=0. Instruction, InstrPC and InstrPCPlus4 hold their last values; decode must ignore them.
- Instruction, InstrPC and InstrPCPlus4 always reflect the FIFO head (registered storage). No combinational path runs from ImemInstruction to decode outputs.
- Pointers wrap modulo DEPTH.

## Timing
- Fetch-to-valid latency is 1 cycle. A word addressed in cycle N appears at the head in cycle N+1 if the FIFO was empty.
- After reset release, the first edge pushes RESET_PC. InstrValid=1 from the following cycle.
- Sustained throughput is 1 instruction/cycle while InstrReady=1 and FetchEnable=1. Count stays at 1 in steady state.
- Redirect penalty: BranchTaken sampled at the end of cycle N.
  - Cycle N+1: ImemAddress=target, InstrValid=0.
  - Cycle N+2: InstrValid=1, InstrPC=target.
- Stall: with InstrReady=0, the FIFO fills in DEPTH cycles, then FetchPC freezes. On the first cycle InstrReady returns to 1, one entry pops and one new entry is pushed in the same cycle.
- Reset asserted mid-operation clears all state immediately, independent of Clk. Fetch resumes at RESET_PC.
- Outputs are glitch-free relative to Clk, except ImemAddress during asynchronous reset.

## Test plan
- Memory preloaded with mem[i]=i*3; reset, then InstrReady=1 -> InstrPC sequence 0,4,8,... with Instruction 0,3,6,...; first InstrValid=1 exactly one cycle after the first edge.
- InstrReady=0 for 8 cycles -> FifoCount reaches 4 and holds; ImemAddress frozen at 0x10. Release -> heads 0,4,8,C,10,14 with no gap or duplicate.
- BranchTaken with BranchTarget=0x43 while FIFO holds 3 entries -> FifoCount=0 next cycle; ImemAddress=0x40; two cycles later InstrPC=0x40, Instruction=mem[16]=48.
- Redirect coincident with pop and a full FIFO -> popped head is counted accepted; no stale entry ever appears after the redirect.
- RESET_PC=32'hFFFF_FFF8 -> InstrPC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; InstrPCPlus4 of FFFF_FFFC = 0.
- Reset_n pulsed low between clock edges while the FIFO holds 2 entries -> InstrValid=0 and FifoCount=0 immediately; fetch restarts at RESET_PC.
